my_press_decoder: RTL
=====================

// Module: my_press_decoder
// PURPOSE
//  Consumes the clean, clk-synchronous level produced by the button debouncer and classifies
//  each press. Outputs: short press on release, long press once a hold threshold is reached,
//  and auto-repeat pulses while the button stays held. Pulses feed downstream control logic
//  (register load/incr strobes, menu stepping) directly.
// PARAMETERS
//  CNT_WIDTH     25          width of hold/repeat counter; must satisfy 2**CNT_WIDTH >= max(LONG_TICKS, REPEAT_TICKS)
//  LONG_TICKS    25_000_000  hold cycles before long_press (0.5 s @ 50 MHz); >= 2
//  REPEAT_TICKS  5_000_000   cycles between repeat_pulse while long-held (100 ms @ 50 MHz); >= 2
// PORTS
//  asynch_nreset  in   1  reset, asynchronous, active-low
//  clk            in   1  clock
//  btn_level      in   1  debounced button level, active-high, already synchronous to clk
//  short_press    out  1  1-cycle pulse: released before LONG_TICKS reached
//  long_press     out  1  1-cycle pulse: hold reached LONG_TICKS
//  repeat_pulse   out  1  1-cycle pulse every REPEAT_TICKS while in LONG_HELD
//  held           out  1  level: 1 while state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, counter=0, all outputs 0. Reset mid-press aborts with no pulse.
//  - All outputs registered; a condition sampled at edge k shows on outputs after edge k+1.
//  - Pulses are exactly one cycle wide; at most one of short/long/repeat is high in any cycle.
//  - Counter reset/load value is 0; load and incr never asserted in the same cycle.
//  - States (registered, 2 bits):
//    IDLE:      btn_level=1 -> PRESSED, counter load 0. btn high out of reset counts as a press.
//    PRESSED:   btn_level=0 -> IDLE, short_press=1.
//               else count==LONG_TICKS-1 -> LONG_HELD, long_press=1, counter load 0.
//               else counter incr.
//               Release and threshold in same cycle: release wins (short_press only).
//    LONG_HELD: btn_level=0 -> IDLE, no pulse.
//               else count==REPEAT_TICKS-1 -> repeat_pulse=1, counter load 0.
//               else incr.
//  - Timing: held rises after edge 0 (entry to PRESSED).
//    long_press is high after edge LONG_TICKS.
//    repeat_pulse is high after edges LONG_TICKS + n*REPEAT_TICKS, n>=1.
//  - Counter never wraps: it is reloaded at every threshold; the unused encoding (2'b11)
//    recovers to IDLE with counter load 0.
// STRUCTURE
//  - Shared defs include (my_defs.vh): state codes ST_IDLE, ST_PRESSED, ST_LONG_HELD.
//  - Counter: one instance of existing my_register, WIDTH=CNT_WIDTH, data_input=0,
//    ctrl_load/ctrl_incr driven by the next-state block.
//  - Three always blocks: sequential; next-state/counter control; output.
// TESTING (bench params: CNT_WIDTH=4, LONG_TICKS=8, REPEAT_TICKS=3)
//  1. Reset asserted, btn_level=0 -> all outputs 0.
//     Deassert and run 20 cycles idle -> outputs stay 0.
//  2. btn high 5 cycles, then low -> held=1 for 5 cycles.
//     short_press one cycle after low is sampled; long_press never asserts.
//  3. btn high 20 cycles -> long_press after edge 8.
//     repeat_pulse after edges 11, 14, 17, 20. Release -> held=0, no short_press.
//  4. btn low sampled exactly at edge 8 (count==7) -> short_press only; long_press stays 0.
//  5. Reset asserted during LONG_HELD, btn held high -> outputs 0 immediately.
//     After deassert: held=1 next edge, long_press 8 cycles later.
//  6. btn high for 1 cycle -> PRESSED then IDLE.
//     short_press pulses once; held high exactly 1 cycle.

Source files
------------

// File: rtl/my_press_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : my_press_decoder_pkg
// Description : State encoding and output bundle shared by the press decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package my_press_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PRESSED   = 2'b01,
        ST_LONG_HELD = 2'b10
    } state_t;

    typedef struct packed {
        logic held;
        logic short_press;
        logic long_press;
        logic repeat_pulse;
    } press_out_t;

endpackage : my_press_decoder_pkg
`default_nettype wire

// File: rtl/my_press_decoder_register.sv
`default_nettype none
// ============================================================================
// Module      : my_press_decoder_register
// Description : Loadable up-counter register; load has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module my_press_decoder_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             asynch_nreset,
    input  logic             ctrl_load,
    input  logic             ctrl_incr,
    input  logic [WIDTH-1:0] data_input,
    output logic [WIDTH-1:0] data_output
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge asynch_nreset) begin
        if (!asynch_nreset) begin
            r_data <= '0;
        end else if (ctrl_load) begin
            r_data <= data_input;
        end else if (ctrl_incr) begin
            r_data <= r_data + WIDTH'(1);
        end
    end

    assign data_output = r_data;

endmodule : my_press_decoder_register
`default_nettype wire

// File: rtl/my_press_decoder.sv
`default_nettype none
// ============================================================================
// Module      : my_press_decoder
// Description : Classifies debounced button presses into short, long and
//               auto-repeat pulses, plus a held level.
// Revision    : 1.0 - initial release
// ============================================================================
module my_press_decoder
    import my_press_decoder_pkg::*;
#(
    parameter int CNT_WIDTH    = 25,
    parameter int LONG_TICKS   = 25_000_000,
    parameter int REPEAT_TICKS = 5_000_000
) (
    input  logic asynch_nreset,
    input  logic clk,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_WIDTH-1:0] c_long_last   = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] c_repeat_last = CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] c_zero        = '0;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_load;
    logic                 w_incr;
    logic [CNT_WIDTH-1:0] w_count;
    press_out_t           w_out;
    press_out_t           r_out;

    my_press_decoder_register #(
        .WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk           (clk),
        .asynch_nreset (asynch_nreset),
        .ctrl_load     (w_load),
        .ctrl_incr     (w_incr),
        .data_input    (c_zero),
        .data_output   (w_count)
    );

    always_ff @(posedge clk or negedge asynch_nreset) begin
        if (!asynch_nreset) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            r_out   <= w_out;
        end
    end

    // Release always takes priority over any threshold hit in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_incr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn_level) begin
                    w_next_state = ST_PRESSED;
                    w_load       = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!btn_level) begin
                    w_next_state = ST_IDLE;
                end else if (w_count == c_long_last) begin
                    w_next_state = ST_LONG_HELD;
                    w_load       = 1'b1;
                end else begin
                    w_incr = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                if (!btn_level) begin
                    w_next_state = ST_IDLE;
                end else if (w_count == c_repeat_last) begin
                    w_load = 1'b1;
                end else begin
                    w_incr = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_load       = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_out              = '0;
        w_out.held         = (w_next_state != ST_IDLE);
        w_out.short_press  = (r_state == ST_PRESSED) && !btn_level;
        w_out.long_press   = (r_state == ST_PRESSED) && btn_level && (w_count == c_long_last);
        w_out.repeat_pulse = (r_state == ST_LONG_HELD) && btn_level && (w_count == c_repeat_last);
    end

    assign held         = r_out.held;
    assign short_press  = r_out.short_press;
    assign long_press   = r_out.long_press;
    assign repeat_pulse = r_out.repeat_pulse;

endmodule : my_press_decoder
`default_nettype wire
